// File: rtl/booth_mul_arbiter.sv
// ---------------------------------------------------------------------------
// booth_mul_arbiter
//
// Shares one external combinational 16x16 signed multiplier among N_REQ
// requesters. A round-robin arbiter accepts one operand pair at a time.
// The accepted operands are registered and drive the multiplier for one
// CALC cycle. The 32-bit product is then captured into an output buffer
// and returned with the requester index over a valid/ready channel.
//
// Parameters:
//   N_REQ  number of requesters (2..8)
//   ID_W   width of the requester index, equal to clog2(N_REQ)
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous active-high reset
//   req_valid   per-requester request valid
//   req_ready   per-requester accept (one-hot or zero)
//   req_x       packed multiplicands, requester i at [16*i+15:16*i]
//   req_y       packed multipliers, same packing
//   mul_x       registered operand to the multiplier x input
//   mul_y       registered operand to the multiplier y input
//   mul_z       product returned by the multiplier (same cycle)
//   resp_valid  response valid
//   resp_ready  response accept
//   resp_z      signed 32-bit product
//   resp_id     index of the requester that issued the operands
//   busy        high whenever the block is not IDLE
//
// Optional feature macro: BOOTH_ARB_PRIO0_EN
//   When defined, requester 0 has strict priority and its grants leave the
//   round-robin pointer untouched. Remaining requesters share round-robin.
// ---------------------------------------------------------------------------
module booth_mul_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [16*N_REQ-1:0]   req_x,
    input  logic [16*N_REQ-1:0]   req_y,
    output logic [15:0]           mul_x,
    output logic [15:0]           mul_y,
    input  logic [31:0]           mul_z,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_z,
    output logic [ID_W-1:0]       resp_id,
    output logic                  busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]      state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] op_id;
    logic [15:0]     op_x;
    logic [15:0]     op_y;

    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] scan_idx;
    logic [ID_W-1:0] rr_next;
    logic            any_valid;
    logic            grant_ok;
    logic            grant;
    logic            rr_update;
    logic [15:0]     x_arr [N_REQ];
    logic [15:0]     y_arr [N_REQ];

    // Unpack the flat operand buses so the winner can index them directly.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            x_arr[i] = req_x[16*i +: 16];
            y_arr[i] = req_y[16*i +: 16];
        end
    end

    // Scan from the rr pointer upward. The loop runs from the farthest
    // offset down to offset zero so the closest valid requester is the last
    // one written and therefore wins. With the priority option, requester 0
    // is excluded from the scan and overrides the result when it is valid.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        scan_idx  = '0;
        rr_update = 1'b1;
        for (int i = N_REQ-1; i >= 0; i--) begin
            scan_idx = ID_W'((int'(rr_ptr) + i) % N_REQ);
`ifdef BOOTH_ARB_PRIO0_EN
            if (scan_idx != '0 && req_valid[scan_idx]) begin
`else
            if (req_valid[scan_idx]) begin
`endif
                winner    = scan_idx;
                any_valid = 1'b1;
            end
        end
`ifdef BOOTH_ARB_PRIO0_EN
        if (req_valid[0]) begin
            winner    = '0;
            any_valid = 1'b1;
            rr_update = 1'b0;
        end
`endif
    end

    // A new operation may be accepted from IDLE, or from RESP in the same
    // cycle the pending response is taken by the consumer.
    always_comb begin
        grant_ok = (state == S_IDLE) || ((state == S_RESP) && resp_ready);
        grant    = grant_ok && any_valid;
        rr_next  = (winner == ID_W'(N_REQ-1)) ? '0 : winner + ID_W'(1);
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    // The operand registers feed the multiplier directly; they only change
    // on a grant, so outside CALC they keep the last operands issued.
    assign mul_x = op_x;
    assign mul_y = op_y;
    assign busy  = (state != S_IDLE);

    // Main control: accept operands on a grant, capture the product at the
    // end of CALC, and hold the response until the consumer takes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            op_x       <= '0;
            op_y       <= '0;
            op_id      <= '0;
            resp_valid <= 1'b0;
            resp_z     <= '0;
            resp_id    <= '0;
        end else begin
            if (grant) begin
                op_x  <= x_arr[winner];
                op_y  <= y_arr[winner];
                op_id <= winner;
                if (rr_update) begin
                    rr_ptr <= rr_next;
                end
            end
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    resp_z     <= mul_z;
                    resp_id    <= op_id;
                    resp_valid <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= grant ? S_CALC : S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
